fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller in front of a combinational
// program ROM. Owns the PC, drives rom_addr straight from the PC register,
// captures {PC, ROM word} into a 2-entry skid buffer and presents the head
// to the decoder over a valid/ready handshake. Supports jump redirect
// (flush + reload PC) and halt (resumed only by a redirect).
//
// Optional feature: define FETCH_PERF_EN to add the saturating 32-bit
// fetch_count / stall_count performance counters and their output ports.

`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module fetch_sequencer #(
  parameter int                ADDR_W   = `ADDR_BITS,
  parameter int                INSTR_W  = 2*`DATA_BITS,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt_req,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  logic [0:0]         state_reg;
  logic [0:0]         state_next;
  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  pc_next;

  // Buffer: the head entry lives directly in the output registers, the
  // second entry (tail) sits behind it.
  logic [1:0]         count_reg;
  logic [1:0]         count_next;
  logic [INSTR_W-1:0] head_data_reg;
  logic [INSTR_W-1:0] head_data_next;
  logic [ADDR_W-1:0]  head_pc_reg;
  logic [ADDR_W-1:0]  head_pc_next;
  logic [INSTR_W-1:0] tail_data_reg;
  logic [INSTR_W-1:0] tail_data_next;
  logic [ADDR_W-1:0]  tail_pc_reg;
  logic [ADDR_W-1:0]  tail_pc_next;

  logic pop;
  logic push;
  logic full;

  assign full = (count_reg == 2'd2);
  assign pop  = (count_reg != 2'd0) & instr_ready;
  // A redirect suppresses the fetch of that cycle; a full buffer still
  // accepts a new word when its head leaves in the same cycle.
  assign push = (state_reg == ST_FETCH) & ~redirect_valid & (~full | pop);

  assign rom_addr    = pc_reg;
  assign instr_valid = (count_reg != 2'd0);
  assign instr_data  = head_data_reg;
  assign instr_pc    = head_pc_reg;
  assign halted      = (state_reg == ST_HALT);

  // Next PC and sequencer state; redirect outranks halt.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect_valid) begin
      state_next = ST_FETCH;
      pc_next    = redirect_addr;
    end else begin
      if (push) begin
        pc_next = pc_reg + ADDR_W'(1);
      end
      if ((state_reg == ST_FETCH) && halt_req) begin
        state_next = ST_HALT;
      end
    end
  end

  // Register PC and state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next buffer contents. Head registers keep their last value when the
  // buffer empties so the outputs do not toggle while invalid.
  always_comb begin
    count_next     = count_reg;
    head_data_next = head_data_reg;
    head_pc_next   = head_pc_reg;
    tail_data_next = tail_data_reg;
    tail_pc_next   = tail_pc_reg;
    if (redirect_valid) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            head_data_next = rom_data;
            head_pc_next   = pc_reg;
          end else begin
            tail_data_next = rom_data;
            tail_pc_next   = pc_reg;
          end
          count_next = count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) begin
            head_data_next = tail_data_reg;
            head_pc_next   = tail_pc_reg;
          end
          count_next = count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_data_next = rom_data;
            head_pc_next   = pc_reg;
          end else begin
            head_data_next = tail_data_reg;
            head_pc_next   = tail_pc_reg;
            tail_data_next = rom_data;
            tail_pc_next   = pc_reg;
          end
        end
        default: begin
          count_next = count_reg;
        end
      endcase
    end
  end

  // Register the skid buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg     <= 2'd0;
      head_data_reg <= '0;
      head_pc_reg   <= '0;
      tail_data_reg <= '0;
      tail_pc_reg   <= '0;
    end else begin
      count_reg     <= count_next;
      head_data_reg <= head_data_next;
      head_pc_reg   <= head_pc_next;
      tail_data_reg <= tail_data_next;
      tail_pc_reg   <= tail_pc_next;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] stall_count_reg;
  logic        stall;

  // A stall is a fetch-state cycle that could not fetch: buffer full, no pop.
  assign stall       = (state_reg == ST_FETCH) & full & ~pop;
  assign fetch_count = fetch_count_reg;
  assign stall_count = stall_count_reg;

  // Saturating performance counters, cleared by reset and redirect.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      fetch_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      if (push && (fetch_count_reg != 32'hFFFF_FFFF)) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end
`endif

endmodule
